// File: rtl/misr_sig_engine.sv
// Galois-LFSR signature register: compresses serial/parallel data into a signature (MISR/SISR)
// or free-runs as a pattern generator; a start/done session compares against a golden value.
module misr_sig_engine #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h1D,
    parameter int               IN_W  = 1,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [WIDTH-1:0] exp_sig,
    input  logic             d_valid,
    input  logic [IN_W-1:0]  d_in,
    output logic [WIDTH-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Stage 0 is always fed back regardless of POLY[0].
    localparam logic [WIDTH-1:0] FB_MASK = POLY | WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             mode_q, mode_d;

    logic [WIDTH-1:0] din_ext;
    logic [WIDTH-1:0] step_sig;
    logic             accept;

    always_comb begin
        din_ext = '0;
        if (!mode_q) din_ext[IN_W-1:0] = d_in;
        step_sig = {sig_q[WIDTH-2:0], 1'b0} ^ din_ext ^ (sig_q[WIDTH-1] ? FB_MASK : '0);
    end

    assign accept = (state_q == S_RUN) && d_valid && (cnt_q != '0);

    // State register and session datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            exp_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic; start overrides everything, including an in-flight session.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        mode_d  = mode_q;
        if (start) begin
            sig_d   = seed_i;
            cnt_d   = len_i;
            exp_d   = exp_sig;
            mode_d  = mode;
            state_d = (len_i == '0) ? S_DONE : S_RUN;
        end else if (accept) begin
            sig_d = step_sig;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
    end

    always_comb begin
        sig  = sig_q;
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        pass = done && (sig_q == exp_q);
    end

endmodule
